// File: rtl/muldiv_unit.sv
`default_nettype none
// ======================================================================
// muldiv_unit - iterative radix-2 multiply / restoring divide with HI/LO
// Rev 1.0
// ======================================================================
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             abort_i,
  input  logic             hilo_read_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             stall_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   araw_q, araw_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;
  logic               rem_neg_q, rem_neg_d;
  logic               dvz_q, dvz_d;
  logic               done_q, done_d;

  logic               w_start_ok;
  logic               w_sa, w_sb;
  logic [WIDTH-1:0]   w_mag_a, w_mag_b;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_acc;
  logic [WIDTH:0]     w_rem_sh, w_diff;
  logic [2*WIDTH-1:0] w_div_acc;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo, w_rem;

  assign w_start_ok = start_i & ~abort_i;
  assign w_sa       = ~op_i[0] & a_i[WIDTH-1];
  assign w_sb       = ~op_i[0] & b_i[WIDTH-1];
  assign w_mag_a    = w_sa ? -a_i : a_i;
  assign w_mag_b    = w_sb ? -b_i : b_i;

  // Multiply: low half holds the multiplier, shifted out LSB first.
  assign w_mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
  assign w_mul_acc = {w_mul_sum, acc_q[WIDTH-1:1]};

  // Divide: {remainder, dividend/quotient}; a borrow in bit WIDTH means restore.
  assign w_rem_sh  = acc_q[2*WIDTH-1:WIDTH-1];
  assign w_diff    = w_rem_sh - {1'b0, opnd_q};
  assign w_div_acc = w_diff[WIDTH] ? {w_rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                   : {w_diff[WIDTH-1:0],   acc_q[WIDTH-2:0], 1'b1};

  assign w_prod = neg_q     ? -acc_q                  : acc_q;
  assign w_quo  = neg_q     ? -acc_q[WIDTH-1:0]       : acc_q[WIDTH-1:0];
  assign w_rem  = rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (w_start_ok && !op_i[2]) state_d = S_CALC;
      S_CALC: begin
        if (abort_i)                         state_d = S_IDLE;
        else if (cnt_q == CNT_W'(1))         state_d = S_FIX;
      end
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_o  = (state_q != S_IDLE);
    stall_o = busy_o & (hilo_read_i | start_i);
    done_o  = done_q;
    hi_o    = hi_q;
    lo_o    = lo_q;
  end

  always_comb begin
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    araw_d    = araw_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    dvz_d     = dvz_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (w_start_ok && !op_i[2]) begin
          is_div_d  = op_i[1];
          neg_d     = w_sa ^ w_sb;
          rem_neg_d = w_sa;
          dvz_d     = op_i[1] & (b_i == '0);
          araw_d    = a_i;
          cnt_d     = CNT_W'(WIDTH);
          acc_d     = {{WIDTH{1'b0}}, (op_i[1] ? w_mag_a : w_mag_b)};
          opnd_d    = op_i[1] ? w_mag_b : w_mag_a;
        end else if (w_start_ok && op_i == OP_MTHI) begin
          hi_d = a_i;
        end else if (w_start_ok && op_i == OP_MTLO) begin
          lo_d = a_i;
        end
      end
      S_CALC: begin
        if (!abort_i) begin
          cnt_d = cnt_q - CNT_W'(1);
          acc_d = is_div_q ? w_div_acc : w_mul_acc;
        end
      end
      S_FIX: begin
        if (!abort_i) begin
          done_d = 1'b1;
          if (!is_div_q) begin
            hi_d = w_prod[2*WIDTH-1:WIDTH];
            lo_d = w_prod[WIDTH-1:0];
          end else if (dvz_q) begin
            hi_d = araw_q;
            lo_d = '1;
          end else begin
            hi_d = w_rem;
            lo_d = w_quo;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      araw_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      dvz_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      araw_q    <= araw_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      dvz_q     <= dvz_d;
      done_q    <= done_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ======================================================================
// tb_muldiv_unit - directed self-checking bench for muldiv_unit
// Rev 1.0
// ======================================================================
module tb_muldiv_unit;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam logic [2:0] OP_NOP   = 3'b110;

  logic        clk, rst_n, start, abort, hilo;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done, stall;
  logic [31:0] hi, lo;

  int tests = 0;
  int fails = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .start_i     (start),
    .op_i        (op),
    .a_i         (a),
    .b_i         (b),
    .abort_i     (abort),
    .hilo_read_i (hilo),
    .busy_o      (busy),
    .done_o      (done),
    .stall_o     (stall),
    .hi_o        (hi),
    .lo_o        (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a negedge; returns at the negedge where Done is seen (or on timeout).
  task automatic do_op(input logic [2:0] o, input logic [31:0] va, input logic [31:0] vb,
                       output int nbusy, output bit got_done);
    start = 1'b1; op = o; a = va; b = vb;
    @(negedge clk);
    start = 1'b0; op = OP_NOP; a = 32'hA5A5_5A5A; b = 32'h0F0F_F0F0;
    nbusy = 0; got_done = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (done === 1'b1) begin
        got_done = 1'b1;
        break;
      end
      if (busy === 1'b1) nbusy++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; hilo = 1'b0;
    op = OP_NOP; a = '0; b = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || stall !== 1'b0) begin
      fails++; $display("FAIL reset_ctrl: busy=%b done=%b stall=%b expected 0/0/0", busy, done, stall);
    end
    tests++;
    if (hi !== 32'h0 || lo !== 32'h0) begin
      fails++; $display("FAIL reset_hilo: hi=%h lo=%h expected 0/0", hi, lo);
    end
  endtask

  task automatic test_mul();
    int nb; bit gd;
    @(negedge clk); do_op(OP_MULT, 32'hFFFF_FFFD, 32'd5, nb, gd);
    tests++;
    if (!gd || nb != 33) begin
      fails++; $display("FAIL mult_latency: busy_cycles=%0d done=%0b expected 33/1", nb, gd);
    end
    tests++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFF1) begin
      fails++; $display("FAIL mult_neg3x5: hi=%h lo=%h expected ffffffff/fffffff1", hi, lo);
    end
    @(negedge clk);
    tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL done_pulse: done=%b busy=%b expected 0/0", done, busy);
    end
    do_op(OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, nb, gd);
    tests++;
    if (!gd || hi !== 32'h0 || lo !== 32'h1) begin
      fails++; $display("FAIL mult_neg1xneg1: done=%0b hi=%h lo=%h expected 1/0/1", gd, hi, lo);
    end
    @(negedge clk); do_op(OP_MULTU, 32'hFFFF_FFFF, 32'd2, nb, gd);
    tests++;
    if (!gd || hi !== 32'h1 || lo !== 32'hFFFF_FFFE) begin
      fails++; $display("FAIL multu: done=%0b hi=%h lo=%h expected 1/1/fffffffe", gd, hi, lo);
    end
  endtask

  task automatic test_div();
    int nb; bit gd;
    @(negedge clk); do_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, nb, gd);
    tests++;
    if (!gd || nb != 33 || lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin
      fails++; $display("FAIL div_neg7by2: done=%0b nb=%0d lo=%h hi=%h expected 1/33/fffffffd/ffffffff", gd, nb, lo, hi);
    end
    @(negedge clk); do_op(OP_DIVU, 32'd100, 32'd7, nb, gd);
    tests++;
    if (!gd || lo !== 32'd14 || hi !== 32'd2) begin
      fails++; $display("FAIL divu_100by7: done=%0b lo=%h hi=%h expected 1/e/2", gd, lo, hi);
    end
    @(negedge clk); do_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, nb, gd);
    tests++;
    if (!gd || lo !== 32'hFFFF_FFFD || hi !== 32'd1) begin
      fails++; $display("FAIL div_7byneg2: done=%0b lo=%h hi=%h expected 1/fffffffd/1", gd, lo, hi);
    end
  endtask

  task automatic test_div_edge();
    int nb; bit gd;
    @(negedge clk); do_op(OP_DIVU, 32'd7, 32'd0, nb, gd);
    tests++;
    if (!gd || nb != 33 || lo !== 32'hFFFF_FFFF || hi !== 32'd7) begin
      fails++; $display("FAIL divu_by0: done=%0b nb=%0d lo=%h hi=%h expected 1/33/ffffffff/7", gd, nb, lo, hi);
    end
    @(negedge clk); do_op(OP_DIV, 32'hFFFF_FFFB, 32'd0, nb, gd);
    tests++;
    if (!gd || lo !== 32'hFFFF_FFFF || hi !== 32'hFFFF_FFFB) begin
      fails++; $display("FAIL div_neg_by0: done=%0b lo=%h hi=%h expected 1/ffffffff/fffffffb", gd, lo, hi);
    end
    @(negedge clk); do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, nb, gd);
    tests++;
    if (!gd || lo !== 32'h8000_0000 || hi !== 32'h0) begin
      fails++; $display("FAIL div_overflow: done=%0b lo=%h hi=%h expected 1/80000000/0", gd, lo, hi);
    end
  endtask

  task automatic test_mthi_mtlo();
    @(negedge clk);
    start = 1'b1; op = OP_MTHI; a = 32'h1234_5678;
    @(negedge clk);
    tests++;
    if (hi !== 32'h1234_5678 || busy !== 1'b0 || done !== 1'b0) begin
      fails++; $display("FAIL mthi: hi=%h busy=%b done=%b expected 12345678/0/0", hi, busy, done);
    end
    op = OP_MTLO; a = 32'h9ABC_DEF0;
    @(negedge clk);
    tests++;
    if (lo !== 32'h9ABC_DEF0 || hi !== 32'h1234_5678 || busy !== 1'b0 || done !== 1'b0) begin
      fails++; $display("FAIL mtlo: lo=%h hi=%h busy=%b done=%b expected 9abcdef0/12345678/0/0", lo, hi, busy, done);
    end
    op = OP_NOP; a = 32'hFFFF_0000;
    @(negedge clk);
    op = 3'b111;
    @(negedge clk);
    tests++;
    if (hi !== 32'h1234_5678 || lo !== 32'h9ABC_DEF0 || busy !== 1'b0) begin
      fails++; $display("FAIL nop: hi=%h lo=%h busy=%b expected 12345678/9abcdef0/0", hi, lo, busy);
    end
    op = OP_MTHI; abort = 1'b1;
    @(negedge clk);
    tests++;
    if (hi !== 32'h1234_5678) begin
      fails++; $display("FAIL abort_blocks_mthi: hi=%h expected 12345678", hi);
    end
    op = OP_MULT; b = 32'd3;
    @(negedge clk);
    start = 1'b0; abort = 1'b0; op = OP_NOP;
    tests++;
    if (busy !== 1'b0) begin
      fails++; $display("FAIL abort_blocks_mult: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_stall();
    int cyc; int bad; bit seen;
    logic exp_stall;
    @(negedge clk);
    start = 1'b1; op = OP_MULT; a = 32'd2; b = 32'd3;
    @(negedge clk);
    cyc = 1; bad = 0; seen = 1'b0;
    while (cyc < 60 && !seen) begin
      hilo = (cyc >= 3);
      if (cyc == 5) begin
        start = 1'b1; op = OP_MULTU; a = 32'd7; b = 32'd7;
      end else begin
        start = 1'b0; op = OP_NOP;
      end
      #1;
      if (done === 1'b1) begin
        seen = 1'b1;
      end else begin
        exp_stall = (cyc >= 3) && (cyc <= 33);
        if (stall !== exp_stall) bad++;
        @(negedge clk);
        cyc++;
      end
    end
    tests++;
    if (bad != 0) begin
      fails++; $display("FAIL stall_trace: %0d cycles wrong expected 0", bad);
    end
    tests++;
    if (!seen || cyc != 34 || stall !== 1'b0) begin
      fails++; $display("FAIL stall_done_cycle: done=%0b cycle=%0d stall=%b expected 1/34/0", seen, cyc, stall);
    end
    tests++;
    if (hi !== 32'h0 || lo !== 32'd6) begin
      fails++; $display("FAIL stall_result: hi=%h lo=%h expected 0/6", hi, lo);
    end
    hilo = 1'b0;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0) begin
      fails++; $display("FAIL ignored_start: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_abort();
    int dn;
    @(negedge clk); start = 1'b1; op = OP_MTHI; a = 32'hCAFE_0001;
    @(negedge clk); op = OP_MTLO; a = 32'hCAFE_0002;
    @(negedge clk); op = OP_DIV; a = 32'd100; b = 32'd3;
    @(negedge clk); start = 1'b0; op = OP_NOP;
    repeat (9) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'hCAFE_0001 || lo !== 32'hCAFE_0002) begin
      fails++; $display("FAIL abort_calc: busy=%b done=%b hi=%h lo=%h expected 0/0/cafe0001/cafe0002", busy, done, hi, lo);
    end
    dn = 0;
    repeat (40) begin @(negedge clk); if (done === 1'b1) dn++; end
    tests++;
    if (dn != 0) begin
      fails++; $display("FAIL abort_no_done: done_pulses=%0d expected 0", dn);
    end
    start = 1'b1; op = OP_DIVU; a = 32'd9; b = 32'd2;
    @(negedge clk); start = 1'b0; op = OP_NOP;
    repeat (32) @(negedge clk);
    abort = 1'b1;
    #1;
    tests++;
    if (busy !== 1'b1) begin
      fails++; $display("FAIL fix_busy: busy=%b expected 1", busy);
    end
    @(negedge clk);
    abort = 1'b0;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'hCAFE_0001 || lo !== 32'hCAFE_0002) begin
      fails++; $display("FAIL abort_fix: busy=%b done=%b hi=%h lo=%h expected 0/0/cafe0001/cafe0002", busy, done, hi, lo);
    end
  endtask

  task automatic test_reset_midop();
    int dn;
    @(negedge clk); start = 1'b1; op = OP_MULT; a = 32'd3; b = 32'd5;
    @(negedge clk); start = 1'b0; op = OP_NOP;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests++;
    if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0 || done !== 1'b0) begin
      fails++; $display("FAIL reset_midop: busy=%b done=%b hi=%h lo=%h expected 0/0/0/0", busy, done, hi, lo);
    end
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    repeat (40) begin @(negedge clk); if (done === 1'b1) dn++; end
    tests++;
    if (dn != 0 || hi !== 32'h0 || lo !== 32'h0) begin
      fails++; $display("FAIL reset_no_update: done_pulses=%0d hi=%h lo=%h expected 0/0/0", dn, hi, lo);
    end
  endtask

  task automatic test_back_to_back();
    int nb; bit gd;
    @(negedge clk); do_op(OP_MULTU, 32'd3, 32'd4, nb, gd);
    tests++;
    if (!gd || hi !== 32'h0 || lo !== 32'd12) begin
      fails++; $display("FAIL b2b_first: done=%0b hi=%h lo=%h expected 1/0/c", gd, hi, lo);
    end
    do_op(OP_DIVU, 32'd20, 32'd6, nb, gd);
    tests++;
    if (!gd || nb != 33 || hi !== 32'd2 || lo !== 32'd3) begin
      fails++; $display("FAIL b2b_second: done=%0b nb=%0d hi=%h lo=%h expected 1/33/2/3", gd, nb, hi, lo);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_div_edge();
    test_mthi_mtlo();
    test_stall();
    test_abort();
    test_reset_midop();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised iterative multiply/divide unit with HI/LO result registers for the 5-stage MIPS pipeline.
- Sits beside the EX-stage ALU and accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from ID/EX.
- Runs a radix-2 shift-add or restoring-divide datapath over WIDTH cycles.
- Drives a stall request to the hazard detection unit when an MFHI/MFLO or a second mul/div op arrives while busy.

Parameters:
- WIDTH, 32, operand and HI/LO width; must be >= 4.
- CNT_W, $clog2(WIDTH)+1, iteration counter width.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Start  input  1  op request, sampled on a rising edge.
- Op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op.
- A  input  WIDTH  rs operand (dividend / multiplicand / MT source).
- B  input  WIDTH  rt operand (divisor / multiplier).
- Abort  input  1  pipeline flush; cancels an in-flight op.
- HiLoRead  input  1  MFHI/MFLO present in EX.
- Busy  output  1  high while an op is in flight.
- Done  output  1  one-cycle pulse when HI/LO are updated by a mul/div.
- Stall  output  1  Busy & (HiLoRead | Start); combinational.
- Hi  output  WIDTH  HI register.
- Lo  output  WIDTH  LO register.

Behaviour:
- Reset (Reset=0, asynchronous): state IDLE; Hi=0, Lo=0, Busy=0, Done=0, counter=0, internal regs cleared. Reset mid-operation discards the op and leaves no partial HI/LO update.
- States: IDLE, CALC, FIX.
- IDLE:
  - Start & Abort=0 & Op in {MULT, MULTU, DIV, DIVU} at edge E0: latch operand magnitudes (absolute values for signed ops), latch result signs, counter=WIDTH. Move to CALC; Busy=1 after E0.
  - Start & Op=MTHI: Hi<=A at E0. Start & Op=MTLO: Lo<=A at E0. Stay in IDLE; Busy and Done are not asserted.
  - Op 11x: no effect.
- CALC: one iteration per edge at E1..E_WIDTH, decrementing the counter. At counter==1 the next edge moves to FIX.
  - Multiply: 2*WIDTH-bit product accumulator, shift-add LSB first.
  - Divide: restoring division, quotient bit per cycle, MSB first.
- FIX (edge E_WIDTH+1):
  - Apply sign correction.
  - Write Hi/Lo: mul gives Hi=product[2W-1:W], Lo=product[W-1:0]; div gives Lo=quotient, Hi=remainder.
  - Busy<=0, Done<=1 for exactly one cycle, return to IDLE.
  - Latency: Busy high for WIDTH+1 cycles; new Hi/Lo and Done visible together after E_WIDTH+1.
- Signed rules:
  - Product sign = sign(A) xor sign(B).
  - Quotient sign = sign(A) xor sign(B); remainder sign = sign(A).
  - Quotient truncates toward zero.
- Divide by zero (B==0, signed or unsigned): Lo = all ones, Hi = A. Latency is unchanged.
- Signed overflow (most-negative / -1): Lo = most-negative, Hi = 0.
- Start while Busy: ignored. Stall is asserted that cycle, and the pipeline holds the op until Busy falls.
- HiLoRead while Busy: Stall=1. On the Done cycle Stall=0 and Hi/Lo already hold the new values.
- Abort while Busy (CALC or FIX): next edge goes to IDLE, Hi/Lo unchanged, Done stays 0. Abort in IDLE blocks a same-cycle Start, including MTHI/MTLO.
- Start on the Done cycle (IDLE) is accepted normally, giving back-to-back ops.
- Operands are registered at E0; A and B may change after acceptance.

Test Plan:
- WIDTH=32, MULT A=0xFFFFFFFD (-3), B=5 -> after 33 Busy cycles Done=1, Hi=0xFFFFFFFF, Lo=0xFFFFFFF1.
- MULTU A=0xFFFFFFFF, B=2 -> Hi=0x00000001, Lo=0xFFFFFFFE; then DIV A=0xFFFFFFF9 (-7), B=2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF.
- DIVU A=7, B=0 -> Lo=0xFFFFFFFF, Hi=0x00000007. DIV A=0x80000000, B=0xFFFFFFFF -> Lo=0x80000000, Hi=0.
- MTHI A=0x12345678 then MTLO A=0x9ABCDEF0 -> Hi/Lo updated at each edge; Busy and Done never asserted.
- MULT started, HiLoRead=1 from cycle 3 -> Stall=1 through the last Busy cycle, 0 on the Done cycle. Second Start at cycle 5 -> Stall=1 and the op is ignored.
- Abort at cycle 10 of a DIV -> IDLE next edge, Hi/Lo keep prior values, no Done. Reset low at cycle 7 of a MULT -> Hi=Lo=0, Busy=0 immediately.
